// File: rtl/decode_stage.sv
// Decode stage: combinational register-file addressing, a pending-write
// scoreboard that stalls fetch on RAW/WAW hazards, and the ID/EX register.
module decode_stage (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [3:0]  r1_addr_o,
    output logic [3:0]  r2_addr_o,
    input  logic        wb_en_i,
    input  logic [3:0]  wb_addr_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    output logic [1:0]  ex_class_o,
    output logic [3:0]  ex_cond_o,
    output logic [3:0]  ex_opcode_o,
    output logic        ex_set_flags_o,
    output logic        ex_use_imm_o,
    output logic [31:0] ex_imm_o,
    output logic [7:0]  ex_shift_o,
    output logic        ex_wr_en_o,
    output logic [3:0]  ex_wr_addr_o,
    output logic [31:0] ex_pc_o
);

    typedef struct packed {
        logic        valid;
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        set_flags;
        logic        use_imm;
        logic [31:0] imm;
        logic [7:0]  shift;
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] pc;
    } idex_t;

    idex_t       dec, idex_q;
    logic [15:0] pending_q, pending_d, need;
    logic        r1_used, r2_used;
    logic [3:0]  r1, r2;
    logic [31:0] imm8, imm_rot;
    logic [4:0]  rot;
    logic        stall, accept;

    assign imm8    = {24'b0, instr_i[7:0]};
    assign rot     = {instr_i[11:8], 1'b0};
    // A zero rotation shifts left by 32, which yields 0 and leaves imm8 intact.
    assign imm_rot = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.cond  = instr_i[31:28];
        dec.pc    = pc_i;
        r1_used   = 1'b0;
        r2_used   = 1'b0;
        r1        = instr_i[19:16];
        r2        = instr_i[3:0];
        if (instr_i[27:26] == 2'b00) begin
            dec.cls       = 2'd0;
            dec.opcode    = instr_i[24:21];
            dec.set_flags = instr_i[20];
            r1_used       = !(instr_i[24:21] == 4'd13 || instr_i[24:21] == 4'd15);
            if (instr_i[25]) begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_rot;
            end else begin
                r2_used   = 1'b1;
                dec.shift = instr_i[11:4];
            end
            if (instr_i[24:23] != 2'b10) begin
                dec.wr_en   = 1'b1;
                dec.wr_addr = instr_i[15:12];
            end
        end else if (instr_i[27:26] == 2'b01) begin
            dec.cls     = 2'd1;
            dec.opcode  = {instr_i[20], instr_i[23], 2'b00};
            dec.use_imm = 1'b1;
            dec.imm     = {20'b0, instr_i[11:0]};
            r1_used     = 1'b1;
            if (instr_i[20]) begin
                dec.wr_en   = 1'b1;
                dec.wr_addr = instr_i[15:12];
            end else begin
                r2_used = 1'b1;
                r2      = instr_i[15:12];
            end
        end else if (instr_i[27:25] == 3'b101) begin
            dec.cls = 2'd2;
            dec.imm = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
            if (instr_i[24]) begin
                dec.wr_en   = 1'b1;
                dec.wr_addr = 4'd14;
            end
        end else begin
            dec.cls = 2'd3;
        end
    end

    assign r1_addr_o = r1_used ? r1 : 4'd0;
    assign r2_addr_o = r2_used ? r2 : 4'd0;

    always_comb begin
        need = '0;
        if (r1_used)   need[r1] = 1'b1;
        if (r2_used)   need[r2] = 1'b1;
        if (dec.wr_en) need[dec.wr_addr] = 1'b1;
    end

    // R15 is never set in the bitmap, so it never contributes to a stall.
    assign stall         = |(need & pending_q);
    assign instr_ready_o = flush_i || !stall;
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        pending_d = pending_q;
        if (wb_en_i) pending_d[wb_addr_i] = 1'b0;
        if (flush_i && idex_q.valid && idex_q.wr_en) pending_d[idex_q.wr_addr] = 1'b0;
        if (accept && !flush_i && dec.wr_en) pending_d[dec.wr_addr] = 1'b1;
        pending_d[15] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_q <= '0;
            idex_q    <= '0;
        end else begin
            pending_q <= pending_d;
            idex_q    <= (accept && !flush_i) ? dec : '0;
        end
    end

    assign ex_valid_o     = idex_q.valid;
    assign ex_class_o     = idex_q.cls;
    assign ex_cond_o      = idex_q.cond;
    assign ex_opcode_o    = idex_q.opcode;
    assign ex_set_flags_o = idex_q.set_flags;
    assign ex_use_imm_o   = idex_q.use_imm;
    assign ex_imm_o       = idex_q.imm;
    assign ex_shift_o     = idex_q.shift;
    assign ex_wr_en_o     = idex_q.wr_en;
    assign ex_wr_addr_o   = idex_q.wr_addr;
    assign ex_pc_o        = idex_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, hazard/flush/reset sequences,
// and a randomized run against a scoreboard-level reference model.
module tb_decode_stage;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] instr_i, pc_i;
    logic        instr_valid_i, instr_ready_o;
    logic [3:0]  r1_addr_o, r2_addr_o;
    logic        wb_en_i;
    logic [3:0]  wb_addr_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic [1:0]  ex_class_o;
    logic [3:0]  ex_cond_o, ex_opcode_o;
    logic        ex_set_flags_o, ex_use_imm_o;
    logic [31:0] ex_imm_o;
    logic [7:0]  ex_shift_o;
    logic        ex_wr_en_o;
    logic [3:0]  ex_wr_addr_o;
    logic [31:0] ex_pc_o;

    decode_stage dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .instr_i(instr_i), .pc_i(pc_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_class_o(ex_class_o), .ex_cond_o(ex_cond_o),
        .ex_opcode_o(ex_opcode_o), .ex_set_flags_o(ex_set_flags_o),
        .ex_use_imm_o(ex_use_imm_o), .ex_imm_o(ex_imm_o), .ex_shift_o(ex_shift_o),
        .ex_wr_en_o(ex_wr_en_o), .ex_wr_addr_o(ex_wr_addr_o), .ex_pc_o(ex_pc_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [1:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  opc;
        logic        sf;
        logic        ui;
        logic [31:0] imm;
        logic [7:0]  sh;
        logic        wen;
        logic [3:0]  wa;
        logic [31:0] pc;
    } m_ex_t;

    typedef struct packed {
        logic       r1u;
        logic [3:0] r1;
        logic       r2u;
        logic [3:0] r2;
        m_ex_t      ex;
    } m_dec_t;

    bit    pend[16];
    m_ex_t m_ex;

    function automatic m_dec_t mdec(input logic [31:0] w, input logic [31:0] pc);
        m_dec_t d;
        longint unsigned v;
        logic [5:0] r;
        int off;
        d = '0;
        d.ex.valid = 1'b1;
        d.ex.cond  = w[31:28];
        d.ex.pc    = pc;
        if (w[27:26] == 2'b00) begin
            d.ex.opc = w[24:21];
            d.ex.sf  = w[20];
            d.r1u    = (w[24:21] != 4'd13) && (w[24:21] != 4'd15);
            d.r1     = w[19:16];
            if (w[25]) begin
                // rotate right on a doubled copy of the byte
                v = {56'b0, w[7:0]};
                r = {1'b0, w[11:8], 1'b0};
                v = ((v << 32) | v) >> r;
                d.ex.imm = v[31:0];
                d.ex.ui  = 1'b1;
            end else begin
                d.r2u   = 1'b1;
                d.r2    = w[3:0];
                d.ex.sh = w[11:4];
            end
            if (w[24:21] < 4'd8 || w[24:21] > 4'd11) begin
                d.ex.wen = 1'b1;
                d.ex.wa  = w[15:12];
            end
        end else if (w[27:26] == 2'b01) begin
            d.ex.cls = 2'd1;
            d.ex.opc = w[20] ? (w[23] ? 4'hC : 4'h8) : (w[23] ? 4'h4 : 4'h0);
            d.ex.ui  = 1'b1;
            d.ex.imm = {20'b0, w[11:0]};
            d.r1u    = 1'b1;
            d.r1     = w[19:16];
            if (w[20]) begin
                d.ex.wen = 1'b1;
                d.ex.wa  = w[15:12];
            end else begin
                d.r2u = 1'b1;
                d.r2  = w[15:12];
            end
        end else if (w[27:25] == 3'b101) begin
            d.ex.cls = 2'd2;
            off = int'(w[23:0]);
            if (w[23]) off = off - 32'sh100_0000;
            d.ex.imm = off * 4;
            if (w[24]) begin
                d.ex.wen = 1'b1;
                d.ex.wa  = 4'd14;
            end
        end else begin
            d.ex.cls = 2'd3;
        end
        return d;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) if (pend[i]) p[i] = 1'b1;
        return p;
    endfunction

    task automatic check_ex(input m_ex_t e);
        chk("ex_valid", 32'(ex_valid_o), 32'(e.valid));
        chk("ex_class", 32'(ex_class_o), 32'(e.cls));
        chk("ex_cond", 32'(ex_cond_o), 32'(e.cond));
        chk("ex_opcode", 32'(ex_opcode_o), 32'(e.opc));
        chk("ex_set_flags", 32'(ex_set_flags_o), 32'(e.sf));
        chk("ex_use_imm", 32'(ex_use_imm_o), 32'(e.ui));
        chk("ex_imm", ex_imm_o, e.imm);
        chk("ex_shift", 32'(ex_shift_o), 32'(e.sh));
        chk("ex_wr_en", 32'(ex_wr_en_o), 32'(e.wen));
        chk("ex_wr_addr", 32'(ex_wr_addr_o), 32'(e.wa));
        chk("ex_pc", ex_pc_o, e.pc);
    endtask

    task automatic do_reset();
        reset_n_i     = 1'b0;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        wb_en_i       = 1'b0;
        wb_addr_i     = 4'd0;
        instr_i       = 32'h0;
        pc_i          = 32'h0;
        for (int i = 0; i < 16; i++) pend[i] = 1'b0;
        m_ex = '0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)      w[27:26] = 2'b00;
        else if (k < 7) w[27:26] = 2'b01;
        else if (k < 9) w[27:25] = 3'b101;
        else            w[27:25] = ($urandom_range(0, 2) == 0) ? 3'b100 :
                                   (($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111);
        w[19:16] = rreg();
        w[15:12] = rreg();
        w[3:0]   = rreg();
        return w;
    endfunction

    // ---------------- decode vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  r1, r2;
        logic [1:0]  cls;
        logic [3:0]  opc;
        logic        sf, ui, wen;
        logic [3:0]  wa;
        logic [31:0] imm;
        logic [7:0]  sh;
    } vec_t;

    vec_t vt[11];

    initial begin
        m_dec_t      d;
        m_ex_t       e;
        logic [31:0] hold_instr, hold_pc;
        logic        last_acc, exp_ready, stl;
        int          q[$];

        //         instr          r1    r2    cls   opc   sf    ui    wen   wa     imm            sh
        vt[0]  = '{32'hE0813002, 4'd1, 4'd2, 2'd0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd3,  32'h0,         8'h00}; // ADD R3,R1,R2
        vt[1]  = '{32'hE3A004FF, 4'd0, 4'd0, 2'd0, 4'd13,1'b0, 1'b1, 1'b1, 4'd0,  32'hFF000000,  8'h00}; // MOV R0,#0xFF000000
        vt[2]  = '{32'hE3510000, 4'd1, 4'd0, 2'd0, 4'd10,1'b1, 1'b1, 1'b0, 4'd0,  32'h0,         8'h00}; // CMP R1,#0
        vt[3]  = '{32'hEBFFFFFE, 4'd0, 4'd0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 4'd14, 32'hFFFFFFF8,  8'h00}; // BL -8
        vt[4]  = '{32'hE5912004, 4'd1, 4'd0, 2'd1, 4'hC, 1'b0, 1'b1, 1'b1, 4'd2,  32'h4,         8'h00}; // LDR R2,[R1,#4]
        vt[5]  = '{32'hE5012008, 4'd1, 4'd2, 2'd1, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0,  32'h8,         8'h00}; // STR R2,[R1,#-8]
        vt[6]  = '{32'hEE000000, 4'd0, 4'd0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,         8'h00}; // coprocessor -> NOP
        vt[7]  = '{32'hE0421183, 4'd2, 4'd3, 2'd0, 4'd2, 1'b0, 1'b0, 1'b1, 4'd1,  32'h0,         8'h18}; // SUB R1,R2,R3,LSL#3
        vt[8]  = '{32'hE1B01002, 4'd0, 4'd2, 2'd0, 4'd13,1'b1, 1'b0, 1'b1, 4'd1,  32'h0,         8'h00}; // MOVS R1,R2
        vt[9]  = '{32'hE28F0E3F, 4'd15,4'd0, 2'd0, 4'd4, 1'b0, 1'b1, 1'b1, 4'd0,  32'h3F0,       8'h00}; // ADD R0,PC,#0x3F0
        vt[10] = '{32'h0A000003, 4'd0, 4'd0, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0,  32'hC,         8'h00}; // BEQ +12

        // reset state, including an asynchronous assertion away from any edge
        do_reset();
        #1;
        chk("rst_ex_valid", 32'(ex_valid_o), 32'h0);
        chk("rst_ready", 32'(instr_ready_o), 32'h1);
        chk("rst_pending", 32'(dut.pending_q), 32'h0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            instr_i       = vt[i].instr;
            pc_i          = 32'h1000 + 32'(i * 4);
            instr_valid_i = 1'b1;
            #1;
            chk("vec_ready", 32'(instr_ready_o), 32'h1);
            chk("vec_r1", 32'(r1_addr_o), 32'(vt[i].r1));
            chk("vec_r2", 32'(r2_addr_o), 32'(vt[i].r2));
            @(negedge clk_i);
            instr_valid_i = 1'b0;
            #1;
            e = '{1'b1, vt[i].cls, vt[i].instr[31:28], vt[i].opc, vt[i].sf, vt[i].ui,
                  vt[i].imm, vt[i].sh, vt[i].wen, vt[i].wa, 32'h1000 + 32'(i * 4)};
            check_ex(e);
            chk("vec_pending", 32'(dut.pending_q),
                (vt[i].wen && vt[i].wa != 4'd15) ? (32'h1 << vt[i].wa) : 32'h0);
            @(negedge clk_i);
            #1;
            chk("vec_bubble", 32'(ex_valid_o), 32'h0);
        end

        // RAW stall until writeback, then a single issue
        do_reset();
        instr_i = 32'hE0813002; instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_i = 32'hE0834003;
        #1;
        chk("raw_ready0", 32'(instr_ready_o), 32'h0);
        chk("raw_first_valid", 32'(ex_valid_o), 32'h1);
        chk("raw_first_wa", 32'(ex_wr_addr_o), 32'h3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #1;
            chk("raw_stall_ready", 32'(instr_ready_o), 32'h0);
            chk("raw_stall_bubble", 32'(ex_valid_o), 32'h0);
            chk("raw_stall_r1", 32'(r1_addr_o), 32'h3);
        end
        @(negedge clk_i);
        wb_en_i = 1'b1; wb_addr_i = 4'd3;
        #1;
        chk("raw_no_bypass", 32'(instr_ready_o), 32'h0);
        @(negedge clk_i);
        wb_en_i = 1'b0;
        #1;
        chk("raw_release", 32'(instr_ready_o), 32'h1);
        chk("raw_release_bubble", 32'(ex_valid_o), 32'h0);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        #1;
        chk("raw_issue_valid", 32'(ex_valid_o), 32'h1);
        chk("raw_issue_wa", 32'(ex_wr_addr_o), 32'h4);
        chk("raw_issue_pending", 32'(dut.pending_q), 32'h10);
        @(negedge clk_i); #1;
        chk("raw_once", 32'(ex_valid_o), 32'h0);

        // flush squashes ID/EX and the instruction in decode
        do_reset();
        instr_i = 32'hE0815002; instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_i = 32'hE0816002; flush_i = 1'b1;
        #1;
        chk("flush_ready", 32'(instr_ready_o), 32'h1);
        chk("flush_ex_wa", 32'(ex_wr_addr_o), 32'h5);
        @(negedge clk_i);
        flush_i = 1'b0; instr_valid_i = 1'b0;
        #1;
        chk("flush_ex_valid", 32'(ex_valid_o), 32'h0);
        chk("flush_pending", 32'(dut.pending_q), 32'h0);

        // asynchronous reset while stalled with a live ID/EX entry
        do_reset();
        instr_i = 32'hE0813002; instr_valid_i = 1'b1;
        @(negedge clk_i);
        instr_i = 32'hE0834003;
        #1;
        chk("arst_pre_ready", 32'(instr_ready_o), 32'h0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid_o), 32'h0);
        chk("arst_ex_wr_en", 32'(ex_wr_en_o), 32'h0);
        chk("arst_pending", 32'(dut.pending_q), 32'h0);
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("arst_ready", 32'(instr_ready_o), 32'h1);

        // randomized run against the model
        do_reset();
        last_acc   = 1'b1;
        hold_instr = 32'h0;
        hold_pc    = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!last_acc && instr_valid_i && $urandom_range(0, 3) != 0) begin
                instr_i = hold_instr; pc_i = hold_pc;
            end else begin
                instr_i = gen_instr(); pc_i = $urandom;
                instr_valid_i = ($urandom_range(0, 3) != 0);
            end
            hold_instr = instr_i; hold_pc = pc_i;
            flush_i = ($urandom_range(0, 11) == 0);
            q.delete();
            for (int i = 0; i < 16; i++) if (pend[i]) q.push_back(i);
            wb_en_i   = ($urandom_range(0, 1) == 1);
            wb_addr_i = (q.size() > 0) ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'($urandom_range(0, 15));
            #1;
            d   = mdec(instr_i, pc_i);
            stl = (d.r1u && pend[d.r1]) || (d.r2u && pend[d.r2]) || (d.ex.wen && pend[d.ex.wa]);
            exp_ready = flush_i || !stl;
            chk("rnd_ready", 32'(instr_ready_o), 32'(exp_ready));
            chk("rnd_r1", 32'(r1_addr_o), d.r1u ? 32'(d.r1) : 32'h0);
            chk("rnd_r2", 32'(r2_addr_o), d.r2u ? 32'(d.r2) : 32'h0);
            chk("rnd_pending", 32'(dut.pending_q), pend_vec());
            check_ex(m_ex);
            last_acc = instr_valid_i && exp_ready;
            if (wb_en_i) pend[wb_addr_i] = 1'b0;
            if (flush_i && m_ex.valid && m_ex.wen) pend[m_ex.wa] = 1'b0;
            if (last_acc && !flush_i && d.ex.wen && d.ex.wa != 4'd15) pend[d.ex.wa] = 1'b1;
            m_ex = (last_acc && !flush_i) ? d.ex : '0;
            @(negedge clk_i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the pipelined ARM-subset CPU, between fetch and execute. It accepts one instruction per cycle from fetch and drives the register file read addresses combinationally. It latches the decoded control into the ID/EX pipeline register, aligned with the register file's registered read data. A 16-bit pending-write scoreboard stalls fetch on RAW/WAW hazards, and a flush from branch resolution squashes wrong-path work.

## Interface
Parameters: none.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_n_i  input  1  asynchronous, active-low reset.
- instr_i  input  32  fetched instruction.
- pc_i  input  32  address of instr_i.
- instr_valid_i  input  1  instr_i/pc_i valid.
- instr_ready_o  output  1  decode accepts this cycle.
- r1_addr_o, r2_addr_o  output  4 each  register file read addresses (combinational from instr_i).
- wb_en_i  input  1  writeback commits a register this cycle.
- wb_addr_i  input  4  writeback destination.
- flush_i  input  1  branch taken in EX; squash ID/EX and the instruction in decode.
- ex_valid_o  output  1  ID/EX holds a live instruction.
- ex_class_o  output  2  0 data-processing, 1 load/store, 2 branch, 3 undefined (NOP).
- ex_cond_o  output  4  instr[31:28].
- ex_opcode_o  output  4  DP opcode instr[24:21]; LS: {L,U,0,0}; else 0.
- ex_set_flags_o  output  1  DP S bit.
- ex_use_imm_o  output  1  operand 2 is ex_imm_o.
- ex_imm_o  output  32  decoded immediate.
- ex_shift_o  output  8  instr[11:4] for DP register form, else 0.
- ex_wr_en_o, ex_wr_addr_o  output  1, 4  destination write.
- ex_pc_o  output  32  pc of the instruction.

## Operation
- Accept = instr_valid_i && instr_ready_o.
- instr_ready_o = flush_i || !stall.
- stall is true when any used source, or the destination, is in the registered pending bitmap. There is no bypass from same-cycle wb_en_i.
- Register 15 is never tracked: reads of 15 return pc in the register file, and pending[15] is never set.
- Data-processing (instr[27:26]=00):
  - r1 = Rn [19:16], unused for MOV/MVN (13/15).
  - Register form (I=0): r2 = Rm [3:0].
  - Immediate form (I=1): ex_imm_o = imm8 [7:0] rotated right by 2×rot [11:8], ex_use_imm_o=1.
  - Opcodes 8–11 (TST/TEQ/CMP/CMN) do not write; all others write Rd [15:12].
- Load/store (01):
  - r1 = Rn; ex_imm_o = zero-extended imm12; ex_use_imm_o=1.
  - Load writes Rd; store reads Rd as r2.
- Branch (101):
  - ex_imm_o = sign-extend(imm24) << 2; no sources.
  - BL (bit 24) writes R14.
- Anything else: class 3, no sources, no write.
- Unused r*_addr_o drive 0. Unused sources are excluded from the hazard check.
- Scoreboard, next-state priority:
  1. Clear wb_addr_i if wb_en_i.
  2. On flush_i, clear ex_wr_addr_o if ex_valid_o && ex_wr_en_o.
  3. Set the new destination on an accept without flush_i.
  - Set wins over clear on the same register.
- On flush_i, the accepted instruction is consumed and dropped: ex_valid_o ← 0, no scoreboard set.

## Timing
- Reset (asynchronous, immediate): all ex_* outputs 0, pending = 0.
  - instr_ready_o = 1 once reset deasserts, because the bitmap is empty.
  - Reset mid-stall drops the pending state and the held instruction.
- Latency: accept at edge N makes ex_valid_o = 1 after edge N, together with the register file's r1_o/r2_o for the same instruction.
- ex_valid_o drops after one cycle unless another instruction is accepted. EX never backpressures.
- Stall release: writeback at edge N clears the pending bit, so instr_ready_o rises in cycle N+1 and the instruction is accepted at edge N+1.
- While stalled, ex_valid_o = 0 (bubble) and r*_addr_o continue to track instr_i.

## Test plan
- Reset, then ADD R3,R1,R2 (0xE0813002): r1_addr_o=1 and r2_addr_o=2 in the same cycle. Next cycle: ex_valid_o=1, class 0, opcode 4, ex_wr_addr_o=3, pending[3]=1.
- ADD R3,R1,R2 then ADD R4,R3,R3 (0xE0834003): instr_ready_o=0 with ex_valid_o=0 bubbles until wb_en_i/wb_addr_i=3. instr_ready_o=1 the following cycle, and the instruction issues once.
- MOV R0,#0xFF000000 (0xE3A004FF): ex_use_imm_o=1, ex_imm_o=0xFF000000, r1_addr_o=0 unused, no stall even if pending[0]=1 is absent. CMP R1,#0 (0xE3510000): ex_wr_en_o=0.
- BL −8 (0xEBFFFFFE): class 2, ex_imm_o=0xFFFFFFF8, ex_wr_en_o=1, ex_wr_addr_o=14, pending[14]=1.
- Issue ADD R5,R1,R2 (0xE0815002), then assert flush_i with the next instruction valid: next cycle ex_valid_o=0, pending[5]=0, nothing issued.
- Assert reset_n_i low mid-stall: outputs clear without waiting for a clock edge, pending = 0, and instr_ready_o=1 after release.
